// File: rtl/pipe_decode_execute_reg_pkg.sv
// pipe_pkg: shared constants and control bundle for the decode/execute boundary
package pipe_pkg;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    localparam int FLAGWRITE_NZ = 1;
    localparam int FLAGWRITE_CV = 0;
    typedef struct packed {
        logic [3:0] cond;
        logic [1:0] flagwrite;
        logic       branch;
        logic       regwrite;
        logic       memwrite;
        logic       pcsrc;
        logic       nowrite;
        logic       memtoreg;
        logic       alusrc;
        logic [1:0] alucontrol;
    } ctrl_e_t;
    localparam ctrl_e_t CTRL_BUBBLE = '{
        cond: COND_AL, flagwrite: 2'b00, branch: 1'b0, regwrite: 1'b0,
        memwrite: 1'b0, pcsrc: 1'b0, nowrite: 1'b0, memtoreg: 1'b0,
        alusrc: 1'b0, alucontrol: 2'b00
    };
endpackage

// File: rtl/pipe_decode_execute_reg_if.sv
// pipe_decode_execute_reg_if: decode-side fields, hazard controls and execute-side copies
interface pipe_decode_execute_reg_if #(parameter int WIDTH = 32, parameter int RA_W = 4);
    logic             StallE, FlushE;
    logic [3:0]       CondD, CondE;
    logic [1:0]       FlagWriteD, FlagWriteE;
    logic             BranchD, RegWriteD, MemWriteD, PCSrcD, NoWriteD, MemtoRegD, ALUSrcD;
    logic             BranchE, RegWriteE, MemWriteE, PCSrcE, NoWriteE, MemtoRegE, ALUSrcE;
    logic [1:0]       ALUControlD, ALUControlE;
    logic [WIDTH-1:0] RD1D, RD2D, ExtImmD, RD1E, RD2E, ExtImmE;
    logic [RA_W-1:0]  RA1D, RA2D, WA3D, RA1E, RA2E, WA3E;
    logic [3:0]       NextFlagsE, FlagsE;
    logic             ValidE;
    modport master (
        output StallE, FlushE, CondD, FlagWriteD, BranchD, RegWriteD, MemWriteD, PCSrcD,
               NoWriteD, MemtoRegD, ALUSrcD, ALUControlD, RD1D, RD2D, ExtImmD,
               RA1D, RA2D, WA3D, NextFlagsE,
        input  CondE, FlagWriteE, BranchE, RegWriteE, MemWriteE, PCSrcE, NoWriteE,
               MemtoRegE, ALUSrcE, ALUControlE, RD1E, RD2E, ExtImmE, RA1E, RA2E, WA3E,
               FlagsE, ValidE
    );
    modport slave (
        input  StallE, FlushE, CondD, FlagWriteD, BranchD, RegWriteD, MemWriteD, PCSrcD,
               NoWriteD, MemtoRegD, ALUSrcD, ALUControlD, RD1D, RD2D, ExtImmD,
               RA1D, RA2D, WA3D, NextFlagsE,
        output CondE, FlagWriteE, BranchE, RegWriteE, MemWriteE, PCSrcE, NoWriteE,
               MemtoRegE, ALUSrcE, ALUControlE, RD1E, RD2E, ExtImmE, RA1E, RA2E, WA3E,
               FlagsE, ValidE
    );
endinterface

// File: rtl/pipe_decode_execute_reg_flags.sv
// pipe_flags_reg: architectural {N,Z,C,V} register with load enable
module pipe_flags_reg (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] d,
    output logic [3:0] q
);
    always_ff @(posedge clk or posedge reset)
        if (reset) q <= 4'b0000;
        else if (en) q <= d;
endmodule

// File: rtl/pipe_decode_execute_reg.sv
// pipe_decode_execute_reg: D->E pipeline register with stall/flush and the condition flags
module pipe_decode_execute_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int RA_W  = 4
) (
    input logic clk,
    input logic reset,
    pipe_decode_execute_reg_if.slave bus
);
    ctrl_e_t          ctrl, ctrl_d;
    logic [WIDTH-1:0] rd1, rd2, imm;
    logic [RA_W-1:0]  ra1, ra2, wa3;
    logic             valid;
    logic [3:0]       flags;
    logic             load;

    assign ctrl_d = '{
        cond: bus.CondD, flagwrite: bus.FlagWriteD, branch: bus.BranchD,
        regwrite: bus.RegWriteD, memwrite: bus.MemWriteD, pcsrc: bus.PCSrcD,
        nowrite: bus.NoWriteD, memtoreg: bus.MemtoRegD, alusrc: bus.ALUSrcD,
        alucontrol: bus.ALUControlD
    };
    // flush beats stall, so a flushed slot always advances
    assign load = bus.FlushE | ~bus.StallE;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            ctrl  <= CTRL_BUBBLE;
            {rd1, rd2, imm, ra1, ra2, wa3} <= '0;
            valid <= 1'b0;
        end else if (load) begin
            ctrl  <= bus.FlushE ? CTRL_BUBBLE : ctrl_d;
            rd1   <= bus.FlushE ? '0 : bus.RD1D;
            rd2   <= bus.FlushE ? '0 : bus.RD2D;
            imm   <= bus.FlushE ? '0 : bus.ExtImmD;
            ra1   <= bus.FlushE ? '0 : bus.RA1D;
            ra2   <= bus.FlushE ? '0 : bus.RA2D;
            wa3   <= bus.FlushE ? '0 : bus.WA3D;
            valid <= ~bus.FlushE;
        end

    // the instruction leaving E on a flush still commits its flags
    pipe_flags_reg u_flags (
        .clk  (clk),
        .reset(reset),
        .en   (load),
        .d    (bus.NextFlagsE),
        .q    (flags)
    );

    assign bus.CondE       = ctrl.cond;
    assign bus.FlagWriteE  = ctrl.flagwrite;
    assign bus.BranchE     = ctrl.branch;
    assign bus.RegWriteE   = ctrl.regwrite;
    assign bus.MemWriteE   = ctrl.memwrite;
    assign bus.PCSrcE      = ctrl.pcsrc;
    assign bus.NoWriteE    = ctrl.nowrite;
    assign bus.MemtoRegE   = ctrl.memtoreg;
    assign bus.ALUSrcE     = ctrl.alusrc;
    assign bus.ALUControlE = ctrl.alucontrol;
    assign bus.RD1E        = rd1;
    assign bus.RD2E        = rd2;
    assign bus.ExtImmE     = imm;
    assign bus.RA1E        = ra1;
    assign bus.RA2E        = ra2;
    assign bus.WA3E        = wa3;
    assign bus.ValidE      = valid;
    assign bus.FlagsE      = flags;
endmodule

// File: tb/tb_pipe_decode_execute_reg.sv
// tb_pipe_decode_execute_reg: randomized and directed checks against a snapshot model
module tb_pipe_decode_execute_reg;
    import pipe_pkg::*;
    typedef struct packed {
        logic [3:0]  cond;
        logic [1:0]  fw;
        logic        br, rw, mw, pc, nw, m2r, as;
        logic [1:0]  alu;
        logic [31:0] rd1, rd2, imm;
        logic [3:0]  ra1, ra2, wa3;
        logic        valid;
    } e_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic chk_on = 1'b0;
    int total = 0;
    int bad = 0;
    e_t exp, prev;
    logic [3:0] exp_flags;

    pipe_decode_execute_reg_if #(.WIDTH(32), .RA_W(4)) bus ();
    pipe_decode_execute_reg #(.WIDTH(32), .RA_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic e_t bubble();
        e_t e = '0;
        e.cond = COND_AL;
        return e;
    endfunction

    function automatic e_t get_d();
        e_t e;
        e = '{bus.CondD, bus.FlagWriteD, bus.BranchD, bus.RegWriteD, bus.MemWriteD, bus.PCSrcD,
              bus.NoWriteD, bus.MemtoRegD, bus.ALUSrcD, bus.ALUControlD, bus.RD1D, bus.RD2D,
              bus.ExtImmD, bus.RA1D, bus.RA2D, bus.WA3D, 1'b1};
        return e;
    endfunction

    function automatic e_t get_e();
        e_t e;
        e = '{bus.CondE, bus.FlagWriteE, bus.BranchE, bus.RegWriteE, bus.MemWriteE, bus.PCSrcE,
              bus.NoWriteE, bus.MemtoRegE, bus.ALUSrcE, bus.ALUControlE, bus.RD1E, bus.RD2E,
              bus.ExtImmE, bus.RA1E, bus.RA2E, bus.WA3E, bus.ValidE};
        return e;
    endfunction

    function automatic logic condex(logic [3:0] c, logic [3:0] f);
        logic n = f[FLAG_N], z = f[FLAG_Z], cy = f[FLAG_C], v = f[FLAG_V];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] nf(logic [3:0] c, logic [3:0] f, logic [1:0] fw, logic [3:0] a);
        logic [3:0] r = f;
        if (condex(c, f) && fw[FLAGWRITE_NZ]) r[3:2] = a[3:2];
        if (condex(c, f) && fw[FLAGWRITE_CV]) r[1:0] = a[1:0];
        return r;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_d();
        {bus.CondD, bus.FlagWriteD, bus.BranchD, bus.RegWriteD, bus.MemWriteD, bus.PCSrcD,
         bus.NoWriteD, bus.MemtoRegD, bus.ALUSrcD, bus.ALUControlD, bus.RD1D, bus.RD2D,
         bus.ExtImmD, bus.RA1D, bus.RA2D, bus.WA3D} = '0;
        bus.CondD = COND_AL;
    endtask

    task automatic rand_d();
        {bus.CondD, bus.FlagWriteD, bus.BranchD, bus.RegWriteD, bus.MemWriteD, bus.PCSrcD,
         bus.NoWriteD, bus.MemtoRegD, bus.ALUSrcD, bus.ALUControlD} = 17'($urandom);
        bus.RD1D = $urandom;
        bus.RD2D = $urandom;
        bus.ExtImmD = $urandom;
        {bus.RA1D, bus.RA2D, bus.WA3D} = 12'($urandom);
    endtask

    // each E slot is either the last accepted D snapshot or a bubble
    always @(posedge clk or posedge reset)
        if (reset) begin
            exp <= bubble();
            exp_flags <= 4'b0000;
        end else begin
            exp <= bus.FlushE ? bubble() : bus.StallE ? exp : get_d();
            if (!bus.StallE || bus.FlushE) exp_flags <= bus.NextFlagsE;
        end

    always begin
        @(posedge clk);
        #1;
        if (!reset && chk_on) begin
            chk("e_fields", get_e(), exp);
            chk("flags", bus.FlagsE, exp_flags);
            chk("no_x", $isunknown({get_e(), bus.FlagsE}), 0);
        end
    end

    initial begin
        bus.StallE = 0;
        bus.FlushE = 0;
        bus.NextFlagsE = 0;
        clear_d();
        #2 reset = 1;
        #1;
        chk("rst_cond", bus.CondE, 4'hE);
        chk("rst_valid", bus.ValidE, 0);
        chk("rst_fields", get_e(), bubble());
        chk("rst_flags", bus.FlagsE, 0);
        step();
        #3 reset = 0;
        chk_on = 1;
        bus.RD1D = 32'h1234_5678;
        bus.RegWriteD = 1;
        step();
        chk("cap_rd1", bus.RD1E, 32'h1234_5678);
        chk("cap_regwrite", bus.RegWriteE, 1);
        chk("cap_valid", bus.ValidE, 1);

        clear_d();
        bus.WA3D = 4'd5;
        bus.MemWriteD = 1;
        step();
        bus.StallE = 1;
        bus.WA3D = 4'd9;
        bus.NextFlagsE = 4'b0100;
        repeat (3) step();
        chk("stall_wa3", bus.WA3E, 5);
        chk("stall_memwrite", bus.MemWriteE, 1);
        chk("stall_flags", bus.FlagsE, 0);
        bus.StallE = 0;
        step();
        chk("unstall_wa3", bus.WA3E, 9);
        chk("unstall_flags", bus.FlagsE, 4'b0100);

        clear_d();
        bus.RegWriteD = 1;
        bus.BranchD = 1;
        step();
        chk("pre_flush_rw", bus.RegWriteE, 1);
        bus.FlushE = 1;
        bus.NextFlagsE = 4'b1000;
        step();
        chk("flush_rw", bus.RegWriteE, 0);
        chk("flush_br", bus.BranchE, 0);
        chk("flush_cond", bus.CondE, 4'hE);
        chk("flush_valid", bus.ValidE, 0);
        chk("flush_flags", bus.FlagsE, 4'b1000);

        bus.FlushE = 0;
        bus.NextFlagsE = 4'b0011;
        step();
        bus.StallE = 1;
        bus.FlushE = 1;
        bus.NextFlagsE = 4'b0110;
        step();
        chk("both_fields", get_e(), bubble());
        chk("both_flags", bus.FlagsE, 4'b0110);
        bus.StallE = 0;
        bus.FlushE = 0;

        clear_d();
        bus.FlagWriteD = 2'b11;
        bus.RegWriteD = 1;
        bus.NextFlagsE = 4'b0000;
        step();
        clear_d();
        bus.CondD = 4'h0;
        bus.RegWriteD = 1;
        bus.NextFlagsE = nf(exp.cond, exp_flags, exp.fw, 4'b0100);
        step();
        chk("adds_flags", bus.FlagsE, 4'b0100);
        chk("moveq_condex", condex(bus.CondE, bus.FlagsE), 1);
        bus.FlushE = 1;
        bus.NextFlagsE = nf(exp.cond, exp_flags, exp.fw, 4'($urandom));
        step();
        bus.FlushE = 0;
        chk("bubble_inert", nf(bus.CondE, bus.FlagsE, bus.FlagWriteE, 4'hF), bus.FlagsE);
        bus.NextFlagsE = nf(exp.cond, exp_flags, exp.fw, 4'hB);
        step();
        chk("bubble_flags", bus.FlagsE, 4'b0100);

        for (int i = 0; i < 8; i++) begin
            rand_d();
            prev = get_d();
            step();
            chk("b2b", get_e(), prev);
        end

        bus.StallE = 1;
        step();
        #2 reset = 1;
        #1;
        chk("rst_stall_fields", get_e(), bubble());
        chk("rst_stall_flags", bus.FlagsE, 0);
        step();
        #3 reset = 0;
        bus.StallE = 0;
        rand_d();
        prev = get_d();
        step();
        chk("post_rst", get_e(), prev);

        for (int i = 0; i < 300; i++) begin
            rand_d();
            bus.StallE = ($urandom % 4) == 0;
            bus.FlushE = ($urandom % 8) == 0;
            bus.NextFlagsE = nf(exp.cond, exp_flags, exp.fw, 4'($urandom));
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
